// File: rtl/sys_reg_pkg.sv
// ----------------------------------------------------------------------------
// sys_reg_pkg
// Shared constants for the system-bus register responder: data and bus widths,
// register offsets, CTRL bit positions, reset values and the byte-enable
// merge helper used by every byte-enabled register.
// ----------------------------------------------------------------------------
package sys_reg_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned EVT_W  = 8;
   localparam int unsigned CNT_W  = 64;
   localparam int unsigned HALF_W = 32;

   // Register offsets within the decoded address window
   localparam logic [31:0] OFS_ID       = 32'h0000_0000;
   localparam logic [31:0] OFS_SCRATCH  = 32'h0000_0004;
   localparam logic [31:0] OFS_CTRL     = 32'h0000_0008;
   localparam logic [31:0] OFS_STATUS   = 32'h0000_000C;
   localparam logic [31:0] OFS_IRQ_MASK = 32'h0000_0010;
   localparam logic [31:0] OFS_CNT_LO   = 32'h0000_0014;
   localparam logic [31:0] OFS_CNT_HI   = 32'h0000_0018;

   // CTRL bit positions
   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_CLR_BIT = 1;

   // Reset values
   localparam logic [DATA_W-1:0] SCRATCH_RST = '0;
   localparam logic              CTRL_EN_RST = 1'b0;
   localparam logic [EVT_W-1:0]  STATUS_RST  = '0;
   localparam logic [EVT_W-1:0]  MASK_RST    = '0;

   // Replace the bytes of old_v selected by sel with the matching bytes of new_v
   function automatic logic [DATA_W-1:0] be_merge(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [SEL_W-1:0]  sel
   );
      logic [DATA_W-1:0] v;
      v = old_v;
      for (int i = 0; i < int'(SEL_W); i++) begin
         if (sel[i]) v[8*i +: 8] = new_v[8*i +: 8];
      end
      return v;
   endfunction

endpackage

// File: rtl/sys_reg_counter.sv
// ----------------------------------------------------------------------------
// sys_reg_counter
// 64-bit free-running counter with enable and synchronous clear, plus a
// snapshot of the high word taken on a strobe so a low/high split read
// sees a consistent 64-bit value.
// Ports:
//   clk_i, rst_i    clock, async active-high reset
//   en_i            count enable
//   clr_i           clear; wins over en_i in the same cycle
//   snap_i          capture the current (pre-update) high word
//   cnt_o           live counter value
//   snap_hi_o       captured high word
// ----------------------------------------------------------------------------
module sys_reg_counter
   import sys_reg_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic              snap_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [HALF_W-1:0] snap_hi_o
);

   logic [CNT_W-1:0]  r_cnt;
   logic [HALF_W-1:0] r_snap;

   // Snapshot takes the value before this cycle's clear/increment
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt  <= RST_VAL;
         r_snap <= '0;
      end else begin
         if (clr_i) begin
            r_cnt <= '0;
         end else if (en_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (snap_i) begin
            r_snap <= r_cnt[CNT_W-1:HALF_W];
         end
      end
   end

   assign cnt_o     = r_cnt;
   assign snap_hi_o = r_snap;

endmodule

// File: rtl/sys_reg_responder.sv
// ----------------------------------------------------------------------------
// sys_reg_responder
// Slave register bank on the system bus. Every single-cycle read or write
// strobe gets exactly one acknowledge on the following cycle, flagged as an
// error for bad requests (which then have no side effects).
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   sys_addr_i/wdata_i/sel_i       request address, write data, byte enables
//   sys_wen_i/ren_i                write/read strobes
//   sys_rdata_o/err_o/ack_o        registered response
//   evt_i                          event inputs setting STATUS flags
//   cnt_en_o                       CTRL.EN
//   irq_o                          registered OR of STATUS & IRQ_MASK
// ----------------------------------------------------------------------------
module sys_reg_responder
   import sys_reg_pkg::*;
#(
   parameter logic [DATA_W-1:0] ID_VALUE    = 32'h5250_0001,
   parameter int unsigned       DEC_W       = 20,
   parameter logic [CNT_W-1:0]  CNT_RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       sys_addr_i,
   input  logic [DATA_W-1:0] sys_wdata_i,
   input  logic [SEL_W-1:0]  sys_sel_i,
   input  logic              sys_wen_i,
   input  logic              sys_ren_i,
   output logic [DATA_W-1:0] sys_rdata_o,
   output logic              sys_err_o,
   output logic              sys_ack_o,
   input  logic [EVT_W-1:0]  evt_i,
   output logic              cnt_en_o,
   output logic              irq_o
);

   logic [DATA_W-1:0] r_scratch;
   logic              r_en;
   logic [EVT_W-1:0]  r_status;
   logic [EVT_W-1:0]  r_mask;
   logic              r_ack;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;
   logic              r_irq;

   logic [DEC_W-1:0]  w_ofs;
   logic              w_hit_id, w_hit_scratch, w_hit_ctrl, w_hit_status;
   logic              w_hit_mask, w_hit_lo, w_hit_hi, w_mapped;
   logic              w_req, w_err, w_wr_ok, w_rd_ok, w_clr;
   logic [EVT_W-1:0]  w_w1c;
   logic [DATA_W-1:0] w_rdata;
   logic [CNT_W-1:0]  w_cnt;
   logic [HALF_W-1:0] w_snap_hi;
   logic              w_unused;

   // Address decode; bits above DEC_W are ignored
   assign w_ofs         = sys_addr_i[DEC_W-1:0];
   assign w_hit_id      = (w_ofs == DEC_W'(OFS_ID));
   assign w_hit_scratch = (w_ofs == DEC_W'(OFS_SCRATCH));
   assign w_hit_ctrl    = (w_ofs == DEC_W'(OFS_CTRL));
   assign w_hit_status  = (w_ofs == DEC_W'(OFS_STATUS));
   assign w_hit_mask    = (w_ofs == DEC_W'(OFS_IRQ_MASK));
   assign w_hit_lo      = (w_ofs == DEC_W'(OFS_CNT_LO));
   assign w_hit_hi      = (w_ofs == DEC_W'(OFS_CNT_HI));
   assign w_mapped      = w_hit_id | w_hit_scratch | w_hit_ctrl | w_hit_status |
                          w_hit_mask | w_hit_lo | w_hit_hi;

   // Any bad request is acked with error and gates off all side effects
   assign w_req   = sys_wen_i | sys_ren_i;
   assign w_err   = w_req & ((sys_wen_i & sys_ren_i) |
                             (sys_addr_i[1:0] != 2'b00) |
                             ~w_mapped |
                             (sys_wen_i & (w_hit_id | w_hit_lo | w_hit_hi)));
   assign w_wr_ok = sys_wen_i & ~w_err;
   assign w_rd_ok = sys_ren_i & ~w_err;

   assign w_clr = w_wr_ok & w_hit_ctrl & sys_sel_i[0] & sys_wdata_i[CTRL_CLR_BIT];
   assign w_w1c = (w_wr_ok & w_hit_status & sys_sel_i[0]) ? sys_wdata_i[EVT_W-1:0] : '0;

   // Read mux; CLR always reads back as 0
   always_comb begin
      w_rdata = '0;
      if (w_hit_id)           w_rdata = ID_VALUE;
      else if (w_hit_scratch) w_rdata = r_scratch;
      else if (w_hit_ctrl)    w_rdata[CTRL_EN_BIT] = r_en;
      else if (w_hit_status)  w_rdata[EVT_W-1:0] = r_status;
      else if (w_hit_mask)    w_rdata[EVT_W-1:0] = r_mask;
      else if (w_hit_lo)      w_rdata = w_cnt[HALF_W-1:0];
      else if (w_hit_hi)      w_rdata = w_snap_hi;
   end

   sys_reg_counter #(
      .RST_VAL (CNT_RST_VAL)
   ) u_counter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (r_en),
      .clr_i     (w_clr),
      .snap_i    (w_rd_ok & w_hit_lo),
      .cnt_o     (w_cnt),
      .snap_hi_o (w_snap_hi)
   );

   // Registers and response; event set is OR'd after the clear so set wins
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_scratch <= SCRATCH_RST;
         r_en      <= CTRL_EN_RST;
         r_status  <= STATUS_RST;
         r_mask    <= MASK_RST;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_w1c) | evt_i;
         r_irq    <= |(r_status & r_mask);
         r_ack    <= w_req;
         r_err    <= w_err;
         if (w_req) begin
            r_rdata <= w_rd_ok ? w_rdata : '0;
         end
         if (w_wr_ok & w_hit_scratch) begin
            r_scratch <= be_merge(r_scratch, sys_wdata_i, sys_sel_i);
         end
         if (w_wr_ok & w_hit_ctrl & sys_sel_i[0]) begin
            r_en <= sys_wdata_i[CTRL_EN_BIT];
         end
         if (w_wr_ok & w_hit_mask & sys_sel_i[0]) begin
            r_mask <= sys_wdata_i[EVT_W-1:0];
         end
      end
   end

   assign w_unused = &{1'b0, sys_addr_i[31:DEC_W], w_cnt[CNT_W-1:HALF_W]};

   assign sys_rdata_o = r_rdata;
   assign sys_err_o   = r_err;
   assign sys_ack_o   = r_ack;
   assign cnt_en_o    = r_en;
   assign irq_o       = r_irq;

endmodule

// File: tb/tb_sys_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_sys_reg_responder
// Directed and randomized requests against a transaction-level model of the
// register map. The counter is modelled arithmetically from the edge at
// which CTRL was last written.
// ----------------------------------------------------------------------------
module tb_sys_reg_responder;

   localparam logic [31:0] ID_VAL  = 32'h5250_0001;
   localparam logic [63:0] PRELOAD = 64'h0000_0000_FFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  sel;
   logic        wen, ren, err, ack, cnt_en, irq;
   logic [7:0]  evt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model state
   logic [31:0] m_scratch;
   logic        m_en;
   logic [63:0] m_base;
   int          m_base_cyc;
   logic [7:0]  m_status, m_mask;
   logic [31:0] m_snap, m_rdata;
   bit          m_rdata_ok;

   sys_reg_responder #(
      .ID_VALUE    (ID_VAL),
      .DEC_W       (20),
      .CNT_RST_VAL (PRELOAD)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sys_addr_i  (addr),
      .sys_wdata_i (wdata),
      .sys_sel_i   (sel),
      .sys_wen_i   (wen),
      .sys_ren_i   (ren),
      .sys_rdata_o (rdata),
      .sys_err_o   (err),
      .sys_ack_o   (ack),
      .evt_i       (evt),
      .cnt_en_o    (cnt_en),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Counter value after edge c
   function automatic logic [63:0] cnt_at(input int c);
      return m_en ? m_base + 64'(c - m_base_cyc) : m_base;
   endfunction

   function automatic void model_reset();
      m_scratch  = '0;
      m_en       = 1'b0;
      m_base     = PRELOAD;
      m_base_cyc = cyc;
      m_status   = '0;
      m_mask     = '0;
      m_snap     = '0;
      m_rdata    = '0;
      m_rdata_ok = 1'b1;
   endfunction

   // One bus cycle: drive, clock, check response against the model, update model
   task automatic step(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [7:0] e, input string tag);
      logic [31:0] ofs, exp_rd;
      bit req, bad, mapped, ro;
      logic exp_irq;
      int c;
      ofs     = a & 32'h000F_FFFF;
      mapped  = (ofs inside {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18});
      ro      = (ofs inside {32'h00, 32'h14, 32'h18});
      req     = w || r;
      bad     = req && ((w && r) || (a[1:0] != 2'b00) || !mapped || (w && ro));
      exp_irq = |(m_status & m_mask);
      wen = w; ren = r; addr = a; wdata = d; sel = s; evt = e;
      @(posedge clk);
      #1;
      c = cyc;
      wen = 1'b0; ren = 1'b0; evt = '0;
      chk({tag, "/ack"}, 64'(ack), 64'(req));
      chk({tag, "/err"}, 64'(err), 64'(bad));
      chk({tag, "/irq"}, 64'(irq), 64'(exp_irq));
      exp_rd = '0;
      if (r && !bad) begin
         case (ofs)
            32'h00:  exp_rd = ID_VAL;
            32'h04:  exp_rd = m_scratch;
            32'h08:  exp_rd = {31'd0, m_en};
            32'h0C:  exp_rd = {24'd0, m_status};
            32'h10:  exp_rd = {24'd0, m_mask};
            32'h14:  exp_rd = cnt_at(c - 1)[31:0];
            default: exp_rd = m_snap;
         endcase
      end
      if (req && !bad) begin
         m_rdata = exp_rd;
         m_rdata_ok = 1'b1;
      end else if (bad) begin
         m_rdata_ok = 1'b0;
      end
      if (m_rdata_ok) chk({tag, "/rdata"}, 64'(rdata), 64'(m_rdata));
      // Model updates for edge c
      if (r && !bad && ofs == 32'h14) m_snap = cnt_at(c - 1)[63:32];
      if (w && !bad) begin
         if (ofs == 32'h04) begin
            for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
         end
         if (ofs == 32'h08 && s[0]) begin
            m_base     = d[1] ? 64'd0 : cnt_at(c);
            m_base_cyc = c;
            m_en       = d[0];
         end
         if (ofs == 32'h0C && s[0]) m_status = m_status & ~d[7:0];
         if (ofs == 32'h10 && s[0]) m_mask = d[7:0];
      end
      m_status = m_status | e;
      chk({tag, "/cnt_en"}, 64'(cnt_en), 64'(m_en));
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      step(1'b0, 1'b1, a, $urandom, 4'($urandom), 8'h00, tag);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input string tag);
      step(1'b1, 1'b0, a, d, s, 8'h00, tag);
   endtask

   task automatic idle(input logic [7:0] e, input string tag);
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, e, tag);
   endtask

   initial begin
      logic [31:0] ra;
      int kind;
      rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; sel = '0; evt = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      chk("rst/ack",    64'(ack),    64'd0);
      chk("rst/err",    64'(err),    64'd0);
      chk("rst/rdata",  64'(rdata),  64'd0);
      chk("rst/cnt_en", 64'(cnt_en), 64'd0);
      chk("rst/irq",    64'(irq),    64'd0);

      // ID, scratch, byte enables
      rd(32'h00, "rd_id");
      chk("id_const", 64'(rdata), 64'(ID_VAL));
      rd(32'h04, "rd_scratch0");
      wr(32'h04, 32'hDEAD_BEEF, 4'b0101, "wr_scratch");
      rd(32'h04, "rd_scratch1");
      chk("scratch_be", 64'(rdata), 64'h00AD_00EF);

      // Events, mask, irq, W1C
      idle(8'h81, "evt81");
      wr(32'h10, 32'h0000_0001, 4'b0001, "wr_mask");
      idle(8'h00, "irq_wait");
      idle(8'h00, "irq_high");
      wr(32'h0C, 32'h0000_0001, 4'b0001, "w1c_b0");
      idle(8'h00, "irq_fall");
      chk("irq_low", 64'(irq), 64'd0);
      rd(32'h0C, "rd_status80");
      step(1'b1, 1'b0, 32'h0C, 32'h0000_0080, 4'b0001, 8'h80, "w1c_vs_set");
      rd(32'h0C, "rd_status_kept");
      chk("status_set_wins", 64'(rdata), 64'h80);

      // Counter split read across the 32-bit carry
      wr(32'h08, 32'h0000_0001, 4'b0001, "ctrl_en");
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(1, 4)) idle(8'h00, "cnt_idle");
         rd(32'h14, "rd_cnt_lo");
         rd(32'h18, "rd_cnt_hi");
      end
      wr(32'h08, 32'h0000_0003, 4'b0001, "ctrl_clr");
      rd(32'h14, "rd_lo_after_clr");
      chk("clr_zero", 64'(rdata), 64'd0);
      rd(32'h18, "rd_hi_after_clr");
      rd(32'h08, "rd_ctrl");

      // Error cases
      rd(32'h1C, "err_unmapped");
      wr(32'h00, 32'h1234_5678, 4'hF, "err_wr_id");
      rd(32'h05, "err_misaligned");
      wr(32'h14, 32'h1234_5678, 4'hF, "err_wr_lo");
      step(1'b1, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 8'h00, "err_both");
      rd(32'h04, "scratch_unchanged");

      // Back-to-back reads
      rd(32'h00, "b2b_id");
      rd(32'h04, "b2b_scratch");
      rd(32'h10, "b2b_mask");

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 11))
            0:  ra = 32'h00;   1: ra = 32'h04;   2: ra = 32'h08;   3: ra = 32'h0C;
            4:  ra = 32'h10;   5: ra = 32'h14;   6: ra = 32'h18;   7: ra = 32'h1C;
            8:  ra = 32'h06;   9: ra = 32'hABC0_0004;  10: ra = 32'h0008_0004;
            default: ra = 32'h14;
         endcase
         kind = $urandom_range(0, 9);
         step(kind inside {3, 4, 5, 9}, kind inside {6, 7, 8, 9}, ra, $urandom,
              4'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, "rand");
      end

      // Reset during the ack cycle drops the ack
      wen = 1'b0; ren = 1'b1; addr = 32'h00; sel = '0;
      @(posedge clk);
      #1;
      ren = 1'b0;
      chk("pre_rst_ack", 64'(ack), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_drop_ack", 64'(ack), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_no_ack", 64'(ack), 64'd0);
      end
      rd(32'h04, "post_rst_scratch");
      rd(32'h14, "post_rst_cnt_lo");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
